// File: rtl/opc5ls_memio.sv
// OPC5LS memory/IO block: RAM, GPIO latch, FIFO-buffered 8N1 serial transmitter.
// Optional 16-bit free-running timer at 0xFE03 when OPC5LS_MEMIO_TIMER_EN is defined.
module opc5ls_memio #(
    parameter int RAM_AW     = 11,
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        rnw,
    output logic [15:0] rdata,
    output logic [7:0]  gpio,
    output logic        txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    logic [15:0]   ram_r [0:(2**RAM_AW)-1];
    logic [7:0]    fifo_mem_r [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic [7:0]    gpio_r;
    logic          txd_r;
    tx_state_t     state_r;
    tx_state_t     state_next_s;
    logic [15:0]   baud_r;
    logic [15:0]   baud_next_s;
    logic [2:0]    bit_r;
    logic [2:0]    bit_next_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_next_s;
    logic          txd_next_s;
    logic          pop_s;
    logic          push_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          tx_busy_s;
    logic          baud_zero_s;
    logic          io_sel_s;
    logic          wr_s;
    logic          wr_ram_s;
    logic          wr_gpio_s;
    logic          wr_txdata_s;
    logic          wr_status_s;
    logic [15:0]   timer_rd_s;
    logic [15:0]   rdata_s;

    assign io_sel_s     = (address[15:8] == 8'hFE);
    assign wr_s         = ~rnw;
    assign wr_ram_s     = wr_s & ~io_sel_s;
    assign wr_gpio_s    = wr_s & io_sel_s & (address[7:0] == 8'h00);
    assign wr_txdata_s  = wr_s & io_sel_s & (address[7:0] == 8'h01);
    assign wr_status_s  = wr_s & io_sel_s & (address[7:0] == 8'h02);
    assign fifo_full_s  = (count_r == FIFO_FULL_CNT);
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    // Fullness is judged on the pre-edge count; a same-cycle pop does not make room.
    assign push_s       = wr_txdata_s & ~fifo_full_s;
    assign tx_busy_s    = (state_r != ST_IDLE);
    assign baud_zero_s  = (baud_r == 16'h0000);

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_ram_s) begin
            ram_r[address[RAM_AW-1:0]] <= wdata;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy count and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (wr_txdata_s && fifo_full_s) begin
                overflow_r <= 1'b1;
            end else if (wr_status_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // GPIO output latch
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_r <= 8'h00;
        end else if (wr_gpio_s) begin
            gpio_r <= wdata[7:0];
        end
    end

`ifdef OPC5LS_MEMIO_TIMER_EN
    logic [15:0] timer_r;
    logic        wr_timer_s;
    assign wr_timer_s = wr_s & io_sel_s & (address[7:0] == 8'h03);

    // Free-running timer; a CPU write overrides the increment for that edge
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= 16'h0000;
        end else if (wr_timer_s) begin
            timer_r <= wdata;
        end else begin
            timer_r <= timer_r + 16'h0001;
        end
    end
    assign timer_rd_s = timer_r;
`else
    assign timer_rd_s = 16'h0000;
`endif

    // Transmitter state register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            baud_r  <= 16'h0000;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_next_s;
            baud_r  <= baud_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
            txd_r   <= txd_next_s;
        end
    end

    // Transmitter next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) state_next_s = ST_START;
                else               state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (baud_zero_s) state_next_s = ST_DATA;
                else             state_next_s = ST_START;
            end
            ST_DATA: begin
                if (baud_zero_s && (bit_r == 3'd7)) state_next_s = ST_STOP;
                else                                state_next_s = ST_DATA;
            end
            ST_STOP: begin
                if (baud_zero_s) state_next_s = ST_IDLE;
                else             state_next_s = ST_STOP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Transmitter outputs: FIFO pop, counter/shift updates and next txd level
    always_comb begin
        pop_s        = 1'b0;
        baud_next_s  = baud_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        txd_next_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_mem_r[rd_ptr_r];
                    baud_next_s  = BAUD_LAST;
                    bit_next_s   = 3'd0;
                end else begin
                    baud_next_s  = 16'h0000;
                end
            end
            ST_START: begin
                if (baud_zero_s) begin
                    baud_next_s = BAUD_LAST;
                    bit_next_s  = 3'd0;
                end else begin
                    baud_next_s = baud_r - 16'h0001;
                end
            end
            ST_DATA: begin
                if (baud_zero_s) begin
                    baud_next_s  = BAUD_LAST;
                    bit_next_s   = bit_r + 3'd1;
                    shift_next_s = {1'b0, shift_r[7:1]};
                end else begin
                    baud_next_s  = baud_r - 16'h0001;
                end
            end
            ST_STOP: begin
                if (baud_zero_s) baud_next_s = 16'h0000;
                else             baud_next_s = baud_r - 16'h0001;
            end
            default: baud_next_s = 16'h0000;
        endcase
        // txd is registered, so it is derived from the state being entered
        case (state_next_s)
            ST_IDLE:  txd_next_s = 1'b1;
            ST_START: txd_next_s = 1'b0;
            ST_DATA:  txd_next_s = shift_next_s[0];
            ST_STOP:  txd_next_s = 1'b1;
            default:  txd_next_s = 1'b1;
        endcase
    end

    // Zero-wait-state read mux; the CPU samples it on the edge ending the access
    always_comb begin
        rdata_s = 16'h0000;
        if (io_sel_s) begin
            case (address[7:0])
                8'h00:   rdata_s = {8'h00, gpio_r};
                8'h02:   rdata_s = {12'h000, overflow_r, fifo_empty_s, fifo_full_s, tx_busy_s};
                8'h03:   rdata_s = timer_rd_s;
                default: rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = ram_r[address[RAM_AW-1:0]];
        end
    end

    assign rdata = rdata_s;
    assign gpio  = gpio_r;
    assign txd   = txd_r;

endmodule
